sru_pla_cfg_loader: RTL and testbench
=====================================

# sru_pla_cfg_loader

Configuration writer for a bank of `sru_pla_unit` segmented PLAs. It accepts a framed byte stream over a valid/ready interface and assembles each frame in a shadow register. It then commits the frame atomically into the per-unit `RegMux` / `RegMintermORSelect` fields that drive the PLA bank. It sits between the SRU configuration port and the PLA units, so no PLA ever sees a partially written configuration.

## Interface
- `M`, default 2: trigger width per PLA; `SEL_W = $clog2(M)*SEGMENT_SIZE`.
- `SEGMENT_SIZE`, default 2: PLA segment size; `OR_W = 2**SEGMENT_SIZE`.
- `NUM_UNITS`, default 4: number of PLA units configured. Range 1..255.
- Derived, not overridable: `CFG_W = SEL_W+OR_W` and `NBYTES = ceil(CFG_W/8)`.
- `Clk` in 1: single clock.
- `RstN` in 1: asynchronous, active-low reset.
- `CfgValid` in 1: byte on `CfgData` is valid.
- `CfgData` in 8: frame byte.
- `CfgReady` out 1: loader can accept a byte.
- `CfgAbort` in 1: synchronous abort of the current frame.
- `RegMuxFlat` out `NUM_UNITS*SEL_W`: unit u occupies `[(u+1)*SEL_W-1 -: SEL_W]`.
- `RegMintermORSelectFlat` out `NUM_UNITS*OR_W`: unit u occupies `[(u+1)*OR_W-1 -: OR_W]`.
- `CfgDone` out 1: one-cycle pulse; a commit just became visible.
- `CfgErr` out 1: one-cycle pulse; a frame was discarded because its index was out of range.

## Operation
- A byte transfers only on a rising edge where `CfgValid & CfgReady` is true.
- Frame format: one index byte, then `NBYTES` payload bytes, least-significant byte first.
- The assembled payload is `{OR bits, mux bits}`: bits `[SEL_W-1:0]` go to `RegMux`, bits `[CFG_W-1:SEL_W]` go to `RegMintermORSelect`.
- Payload bits at `CFG_W` and above are ignored.
- FSM states: IDLE, PAYLOAD, DISCARD, COMMIT.
- IDLE: `CfgReady`=1. On transfer, latch the index.
  - Index < `NUM_UNITS` → PAYLOAD.
  - Otherwise → DISCARD.
  - Byte counter cleared to 0.
- PAYLOAD: `CfgReady`=1. Each transfer writes the byte into shadow bits `[cnt*8 +: 8]` and increments the counter.
  - The transfer with cnt = `NBYTES-1` → COMMIT.
- DISCARD: `CfgReady`=1. Each transfer is consumed and dropped.
  - The transfer with cnt = `NBYTES-1` → IDLE and pulses `CfgErr`.
- COMMIT: lasts one cycle with `CfgReady`=0.
  - The closing edge writes the shadow register into unit[index]'s fields only.
  - Pulses `CfgDone` and returns to IDLE.
- Other units' fields never change during a commit.
- `CfgAbort`=1 at an edge forces IDLE and clears the counter and shadow. It has priority over any same-cycle transfer, and that byte is not consumed.
  - Active outputs are unchanged.
  - Abort in COMMIT suppresses the commit and the `CfgDone` pulse.
- A new frame's index byte may be accepted in the first IDLE cycle after COMMIT or DISCARD. There are no other idle gaps.
- Reset: state IDLE, counter 0, shadow 0.
  - All of `RegMuxFlat` and `RegMintermORSelectFlat` read 0, so every PLA `Select` is 0.
  - `CfgDone`=0, `CfgErr`=0, `CfgReady`=0 while `RstN` is low and 1 in the first cycle after release.
- Reset asserted mid-frame discards the frame. Fields already committed return to 0.

## Timing
- `CfgReady` is a registered function of state. It never depends combinationally on `CfgValid`.
- Last payload byte accepted at edge N:
  - COMMIT during cycle N→N+1.
  - New field values and `CfgDone`=1 during cycle N+1→N+2.
  - `CfgReady`=1 again in that same cycle.
- Last discard byte accepted at edge N: `CfgErr`=1 and IDLE with `CfgReady`=1 during cycle N→N+1.
- `CfgDone` and `CfgErr` are high for exactly one cycle and never high together.
- Minimum frame period: `NBYTES+2` cycles for a committed frame, `NBYTES+1` for a discarded one.
- All outputs are driven from flops.

## Test plan
- Defaults (M=2, SEG=2, CFG_W=6, NBYTES=1). Send 0x02, 0x2D. Expected: unit2 `RegMux`=2'b01 and `RegMintermORSelect`=4'b1011; `CfgDone` pulses 2 cycles after the last byte; units 0, 1 and 3 stay 0.
- M=8, SEG=2 (CFG_W=10, NBYTES=2). Send 0x01, 0xFA, 0x03. Expected: unit1 `RegMux`=6'b111010 and `RegMintermORSelect`=4'b1111; bits above 9 ignored.
- Defaults. Send 0x04, 0xFF. Expected: `CfgErr` pulse 1 cycle after 0xFF; all outputs stay 0; then 0x00, 0x01 gives unit0 `RegMux`=2'b01.
- Defaults. Send 0x03, then assert `CfgAbort` in COMMIT. Expected: no `CfgDone`; unit3 is unchanged. Also check that `CfgReady` is low for exactly one cycle.
- Random `CfgValid` gaps, with back-to-back frames to all 4 units. Expected: each unit ends with its last written value; the `CfgDone` count equals the frame count.
- Load unit0 with 0x3F, then pulse `RstN` low mid-frame. Expected: all fields 0 and pulses 0 asynchronously; a subsequent frame loads correctly.

Source files
------------

// File: rtl/sru_pla_cfg_loader.sv
// Framed byte-stream configuration writer for a bank of segmented PLA units.
// Each frame is assembled in a shadow register and committed atomically to one unit's fields.
module sru_pla_cfg_loader #(
  parameter  int M            = 2,
  parameter  int SEGMENT_SIZE = 2,
  parameter  int NUM_UNITS    = 4,
  localparam int SEL_W        = $clog2(M) * SEGMENT_SIZE,
  localparam int OR_W         = 2 ** SEGMENT_SIZE,
  localparam int CFG_W        = SEL_W + OR_W,
  localparam int NBYTES       = (CFG_W + 7) / 8
) (
  input  logic                      Clk,
  input  logic                      RstN,
  input  logic                      CfgValid,
  input  logic [7:0]                CfgData,
  output logic                      CfgReady,
  input  logic                      CfgAbort,
  output logic [NUM_UNITS*SEL_W-1:0] RegMuxFlat,
  output logic [NUM_UNITS*OR_W-1:0]  RegMintermORSelectFlat,
  output logic                      CfgDone,
  output logic                      CfgErr
);

  localparam int CNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int SHD_W = NBYTES * 8;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAYLOAD,
    S_DISCARD,
    S_COMMIT
  } state_e;

  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [7:0]                   idx_q, idx_d;
  logic [SHD_W-1:0]             shadow_q, shadow_d;
  logic [NUM_UNITS*SEL_W-1:0]   mux_q, mux_d;
  logic [NUM_UNITS*OR_W-1:0]    or_q, or_d;
  logic                         done_q, done_d;
  logic                         err_q, err_d;
  logic                         ready_q, ready_d;
  logic                         xfer;

  assign xfer = CfgValid & ready_q;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    mux_d    = mux_q;
    or_d     = or_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    if (CfgAbort) begin
      // Abort wins over a same-cycle byte; committed fields are left alone.
      state_d  = S_IDLE;
      cnt_d    = '0;
      shadow_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (xfer) begin
            idx_d   = CfgData;
            cnt_d   = '0;
            state_d = (int'(CfgData) < NUM_UNITS) ? S_PAYLOAD : S_DISCARD;
          end
        end
        S_PAYLOAD: begin
          if (xfer) begin
            shadow_d[8*int'(cnt_q) +: 8] = CfgData;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) state_d = S_COMMIT;
          end
        end
        S_DISCARD: begin
          if (xfer) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
              state_d = S_IDLE;
              err_d   = 1'b1;
            end
          end
        end
        S_COMMIT: begin
          for (int u = 0; u < NUM_UNITS; u++) begin
            if (idx_q == 8'(u)) begin
              mux_d[u*SEL_W +: SEL_W] = shadow_q[SEL_W-1:0];
              or_d[u*OR_W +: OR_W]    = shadow_q[CFG_W-1:SEL_W];
            end
          end
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    ready_d = (state_d != S_COMMIT);
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
  // NOTE: the field registers are reset too: after reset every PLA select must read 0.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      mux_q    <= '0;
      or_q     <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      mux_q    <= mux_d;
      or_q     <= or_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
    end
  end

  assign CfgReady               = ready_q;
  assign CfgDone                = done_q;
  assign CfgErr                 = err_q;
  assign RegMuxFlat             = mux_q;
  assign RegMintermORSelectFlat = or_q;

endmodule

// File: tb/tb_sru_pla_cfg_loader.sv
// Self-checking bench for sru_pla_cfg_loader: vector table, corner sequences and a
// randomized frame stream checked against a frame-level reference model.
module tb_sru_pla_cfg_loader;

  logic        Clk = 1'b0;
  logic        RstN;
  // default-parameter instance (NBYTES=1)
  logic        v, ab, rdy, done, err;
  logic [7:0]  dd;
  logic [7:0]  mux;
  logic [15:0] orv;
  // M=8 instance (NBYTES=2)
  logic        v8, ab8, rdy8, done8, err8;
  logic [7:0]  d8;
  logic [23:0] mux8;
  logic [15:0] or8;

  int n_cmp = 0;
  int n_fail = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0;

  always #5 Clk = ~Clk;

  sru_pla_cfg_loader dut (
    .Clk(Clk), .RstN(RstN), .CfgValid(v), .CfgData(dd), .CfgReady(rdy), .CfgAbort(ab),
    .RegMuxFlat(mux), .RegMintermORSelectFlat(orv), .CfgDone(done), .CfgErr(err)
  );

  sru_pla_cfg_loader #(.M(8), .SEGMENT_SIZE(2), .NUM_UNITS(4)) dut8 (
    .Clk(Clk), .RstN(RstN), .CfgValid(v8), .CfgData(d8), .CfgReady(rdy8), .CfgAbort(ab8),
    .RegMuxFlat(mux8), .RegMintermORSelectFlat(or8), .CfgDone(done8), .CfgErr(err8)
  );

  always @(negedge Clk) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (done && err) both_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Present a byte and hold it until the edge that transfers it; returns 1 time unit after that edge.
  task automatic send_byte(input bit sel8, input logic [7:0] b);
    bit r;
    int n = 0;
    if (sel8) begin v8 = 1'b1; d8 = b; end
    else begin v = 1'b1; dd = b; end
    forever begin
      r = sel8 ? rdy8 : rdy;
      tick();
      if (r) break;
      n++;
      if (n > 50) begin
        check("ready_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  // Reset asserted and released away from clock edges.
  task automatic do_reset();
    v = 1'b0; v8 = 1'b0; ab = 1'b0; ab8 = 1'b0;
    #2 RstN = 1'b0;
    tick();
    tick();
    #2 RstN = 1'b1;
    tick();
  endtask

  typedef struct {
    logic [7:0]  idx;
    logic [7:0]  data;
    bit          commit;
    logic [7:0]  exp_mux;
    logic [15:0] exp_or;
  } vec_t;

  vec_t tbl[6];
  logic [1:0] m_mux[4];
  logic [3:0] m_or[4];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_d, base_e, n_ok, n_bad;
    logic [7:0] idx, dat;

    tbl[0] = '{8'h02, 8'h2D, 1'b1, 8'h10, 16'h0B00};
    tbl[1] = '{8'h04, 8'hFF, 1'b0, 8'h10, 16'h0B00};
    tbl[2] = '{8'h00, 8'h01, 1'b1, 8'h11, 16'h0B00};
    tbl[3] = '{8'h03, 8'hC7, 1'b1, 8'hD1, 16'h1B00};
    tbl[4] = '{8'hFF, 8'h00, 1'b0, 8'hD1, 16'h1B00};
    tbl[5] = '{8'h01, 8'h3E, 1'b1, 8'hD9, 16'h1BF0};

    v = 1'b0; v8 = 1'b0; ab = 1'b0; ab8 = 1'b0; dd = '0; d8 = '0;
    RstN = 1'b0;
    #1;
    check("rst_ready", 32'(rdy), 32'd0);
    check("rst_mux", 32'(mux), 32'd0);
    check("rst_or", 32'(orv), 32'd0);
    check("rst_pulses", 32'({done, err}), 32'd0);
    #20;
    @(negedge Clk) RstN = 1'b1;
    tick();
    check("post_rst_ready", 32'(rdy), 32'd1);
    check("post_rst_pulses", 32'({done, err}), 32'd0);

    // Vector table on the default instance.
    for (int i = 0; i < 6; i++) begin
      send_byte(1'b0, tbl[i].idx);
      send_byte(1'b0, tbl[i].data);
      v = 1'b0;
      if (tbl[i].commit) begin
        check($sformatf("v%0d_commit_ready", i), 32'(rdy), 32'd0);
        check($sformatf("v%0d_done_early", i), 32'(done), 32'd0);
        tick();
        check($sformatf("v%0d_done", i), 32'(done), 32'd1);
        check($sformatf("v%0d_ready_back", i), 32'(rdy), 32'd1);
      end else begin
        check($sformatf("v%0d_err", i), 32'(err), 32'd1);
        check($sformatf("v%0d_ready_err", i), 32'(rdy), 32'd1);
        check($sformatf("v%0d_no_done", i), 32'(done), 32'd0);
      end
      check($sformatf("v%0d_mux", i), 32'(mux), 32'(tbl[i].exp_mux));
      check($sformatf("v%0d_or", i), 32'(orv), 32'(tbl[i].exp_or));
      tick();
      check($sformatf("v%0d_pulse_end", i), 32'({done, err}), 32'd0);
    end

    // Abort while in COMMIT: no commit, no done, ready low for one cycle only.
    send_byte(1'b0, 8'h03);
    send_byte(1'b0, 8'h2A);
    v = 1'b0;
    ab = 1'b1;
    check("abort_commit_ready_low", 32'(rdy), 32'd0);
    tick();
    ab = 1'b0;
    check("abort_no_done", 32'(done), 32'd0);
    check("abort_ready_back", 32'(rdy), 32'd1);
    check("abort_mux", 32'(mux), 32'h0D9);
    check("abort_or", 32'(orv), 32'h1BF0);
    tick();
    check("abort_no_late_done", 32'(done), 32'd0);

    // Wide config (NBYTES=2): abort mid-payload drops the same-cycle byte, then a full frame.
    send_byte(1'b1, 8'h01);
    send_byte(1'b1, 8'h55);
    d8 = 8'h77;
    ab8 = 1'b1;
    tick();
    ab8 = 1'b0;
    v8 = 1'b0;
    check("w_abort_ready", 32'(rdy8), 32'd1);
    tick();
    check("w_abort_no_done", 32'(done8), 32'd0);
    check("w_abort_mux", 32'(mux8), 32'd0);
    send_byte(1'b1, 8'h01);
    send_byte(1'b1, 8'hFA);
    send_byte(1'b1, 8'h03);
    v8 = 1'b0;
    check("w_commit_ready", 32'(rdy8), 32'd0);
    tick();
    check("w_done", 32'(done8), 32'd1);
    check("w_mux", 32'(mux8), 32'h000E80);
    check("w_or", 32'(or8), 32'h00F0);

    // Reset mid-frame clears fields and pulses asynchronously; the partial frame is lost.
    send_byte(1'b0, 8'h00);
    send_byte(1'b0, 8'h3F);
    v = 1'b0;
    tick();
    check("pre_rst_u0_mux", 32'(mux[1:0]), 32'd3);
    check("pre_rst_u0_or", 32'(orv[3:0]), 32'hF);
    send_byte(1'b0, 8'h02);
    v = 1'b0;
    #2 RstN = 1'b0;
    #1;
    check("midrst_mux", 32'(mux), 32'd0);
    check("midrst_or", 32'(orv), 32'd0);
    check("midrst_wide_mux", 32'(mux8), 32'd0);
    check("midrst_pulses", 32'({done, err}), 32'd0);
    check("midrst_ready", 32'(rdy), 32'd0);
    @(posedge Clk);
    #3 RstN = 1'b1;
    @(posedge Clk);
    #1;
    check("midrst_ready_release", 32'(rdy), 32'd1);
    send_byte(1'b0, 8'h00);
    send_byte(1'b0, 8'h01);
    v = 1'b0;
    tick();
    check("after_rst_done", 32'(done), 32'd1);
    check("after_rst_mux", 32'(mux), 32'h01);
    check("after_rst_or", 32'(orv), 32'h0);

    // Randomized frame stream with valid gaps against the frame-level model.
    do_reset();
    for (int u = 0; u < 4; u++) begin
      m_mux[u] = '0;
      m_or[u]  = '0;
    end
    base_d = done_cnt;
    base_e = err_cnt;
    n_ok = 0;
    n_bad = 0;
    for (int f = 0; f < 60; f++) begin
      idx = 8'($urandom_range(0, 4));
      dat = 8'($urandom);
      repeat ($urandom_range(0, 2)) begin v = 1'b0; tick(); end
      send_byte(1'b0, idx);
      repeat ($urandom_range(0, 2)) begin v = 1'b0; tick(); end
      send_byte(1'b0, dat);
      if (idx < 4) begin
        m_mux[idx] = 2'(dat % 4);
        m_or[idx]  = 4'((dat / 4) % 16);
        n_ok++;
      end else begin
        n_bad++;
      end
    end
    v = 1'b0;
    repeat (4) tick();
    for (int u = 0; u < 4; u++) begin
      check($sformatf("rnd_u%0d_mux", u), 32'(mux[u*2 +: 2]), 32'(m_mux[u]));
      check($sformatf("rnd_u%0d_or", u), 32'(orv[u*4 +: 4]), 32'(m_or[u]));
    end
    check("rnd_done_count", 32'(done_cnt - base_d), 32'(n_ok));
    check("rnd_err_count", 32'(err_cnt - base_e), 32'(n_bad));
    check("done_err_overlap", 32'(both_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
